// File: rtl/sha_compress_seq.sv
// ============================================================================
//  Module      : sha_compress_seq (with helper sha_round)
//  Description : Iterative SHA-256 compression, one round per clock using a
//                single shared round datapath and a 16-word sliding message
//                schedule window. Define SHA_COMPRESS_FEEDFORWARD_EN to add
//                the captured chaining value to the final working state.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sha_round (
  input  logic [255:0] state_i,
  input  logic [31:0]  k_i,
  input  logic [31:0]  w_i,
  output logic [255:0] state_o
);

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  logic [31:0] w_a, w_b, w_c, w_d, w_e, w_f, w_g, w_h;
  logic [31:0] w_t1, w_t2;

  assign {w_a, w_b, w_c, w_d, w_e, w_f, w_g, w_h} = state_i;

  assign w_t1 = w_h + big_sigma1(w_e) + ((w_e & w_f) ^ (~w_e & w_g)) + k_i + w_i;
  assign w_t2 = big_sigma0(w_a) + ((w_a & w_b) ^ (w_a & w_c) ^ (w_b & w_c));

  assign state_o = {w_t1 + w_t2, w_a, w_b, w_c, w_d + w_t1, w_e, w_f, w_g};

endmodule

module sha_compress_seq (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [255:0] state_in,
  input  logic [511:0] block_in,
  output logic         busy,
  output logic         done,
  output logic [5:0]   round,
  output logic [255:0] state_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2
  } state_e;

  localparam logic [0:63][31:0] K = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'd0, x[31:10]};
  endfunction

  state_e       state_q, state_d;
  logic [5:0]   round_q, round_d;
  logic [255:0] work_q, work_d;
  logic [511:0] win_q, win_d;     // word t in [511:480], word t+15 in [31:0]
  logic [255:0] out_q, out_d;
  logic         done_q, done_d;

  logic [31:0]  w_wt;
  logic [31:0]  w_kt;
  logic [31:0]  w_wnext;
  logic [255:0] w_round_out;
  logic [255:0] w_result;

  assign w_wt = win_q[511:480];
  assign w_kt = K[round_q];

  // W[t+16] from the window: sigma1(W[t+14]) + W[t+9] + sigma0(W[t+1]) + W[t]
  assign w_wnext = small_sigma1(win_q[63:32]) + win_q[223:192]
                 + small_sigma0(win_q[479:448]) + win_q[511:480];

  sha_round u_round (
    .state_i (work_q),
    .k_i     (w_kt),
    .w_i     (w_wt),
    .state_o (w_round_out)
  );

`ifdef SHA_COMPRESS_FEEDFORWARD_EN
  logic [255:0] hin_q;

  // Keep a private copy of the chaining value so later input changes are harmless
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hin_q <= '0;
    end else if (state_q == IDLE && start) begin
      hin_q <= state_in;
    end
  end

  for (genvar i = 0; i < 8; i++) begin : g_ff
    assign w_result[i*32 +: 32] = hin_q[i*32 +: 32] + work_q[i*32 +: 32];
  end
`else
  assign w_result = work_q;
`endif

  // State, datapath and output registers; reset clears everything at once
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      round_q <= '0;
      work_q  <= '0;
      win_q   <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      work_q  <= work_d;
      win_q   <= win_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end

  // Next-state and datapath control: load, 64 rounds, then publish result
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    work_d  = work_q;
    win_d   = win_q;
    out_d   = out_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          work_d  = state_in;
          win_d   = block_in;
          round_d = 6'd0;
          state_d = ROUND;
        end
      end
      ROUND: begin
        work_d = w_round_out;
        win_d  = {win_q[479:0], w_wnext};
        if (round_q == 6'd63) begin
          state_d = FINAL;        // round index saturates at 63
        end else begin
          round_d = round_q + 6'd1;
        end
      end
      FINAL: begin
        out_d   = w_result;
        done_d  = 1'b1;
        round_d = 6'd0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        round_d = 6'd0;
      end
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign round     = round_q;
  assign state_out = out_q;

endmodule

`default_nettype wire

// File: tb/tb_sha_compress_seq.sv
// ============================================================================
//  Module      : tb_sha_compress_seq
//  Description : Directed bench for sha_compress_seq ("abc" block, ignored
//                starts, mid-block reset, back-to-back blocks, all-zero
//                block). Honours SHA_COMPRESS_FEEDFORWARD_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sha_compress_seq;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  logic [255:0] state_in;
  logic [511:0] block_in;
  logic         busy;
  logic         done;
  logic [5:0]   round;
  logic [255:0] state_out;

  int errors = 0;
  int checks = 0;

  localparam logic [255:0] IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [511:0] ABC = {32'h61626380, 448'd0, 32'h00000018};
  localparam logic [255:0] ABC_DIGEST = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] ABC_RAW    = 256'h506e3058_d39a2165_04d24d6c_b85e2ce9_5ef50f24_fb121210_948d25b6_961f4894;
  localparam logic [255:0] ABC_R1     = 256'h5d6aebcd_6a09e667_bb67ae85_3c6ef372_fa2a4622_510e527f_9b05688c_1f83d9ab;
`ifdef SHA_COMPRESS_FEEDFORWARD_EN
  localparam logic [255:0] ABC_EXP = ABC_DIGEST;
`else
  localparam logic [255:0] ABC_EXP = ABC_RAW;
`endif

  localparam logic [31:0] K_TB [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  sha_compress_seq dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .state_in  (state_in),
    .block_in  (block_in),
    .busy      (busy),
    .done      (done),
    .round     (round),
    .state_out (state_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Textbook full-schedule compression used as the reference
  function automatic logic [255:0] sha_model(input logic [255:0] h, input logic [511:0] m);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, hh, t1, t2, s0, s1;
    for (int t = 0; t < 16; t++) w[t] = m[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      s0 = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
      s1 = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = s1 + w[t-7] + s0 + w[t-16];
    end
    {a, b, c, d, e, f, g, hh} = h;
    for (int t = 0; t < 64; t++) begin
      t1 = hh + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K_TB[t] + w[t];
      t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
`ifdef SHA_COMPRESS_FEEDFORWARD_EN
    return {a + h[255:224], b + h[223:192], c + h[191:160], d + h[159:128],
            e + h[127:96],  f + h[95:64],   g + h[63:32],   hh + h[31:0]};
`else
    return {a, b, c, d, e, f, g, hh};
`endif
  endfunction

  // Runs from edge count lat0 (edges since acceptance) until done, bounded
  task automatic wait_done(input int lat0, input bit poke, output int lat);
    lat = lat0;
    while (!done && lat < 100) begin
      start = poke && (lat == 10 || lat == 40);
      tick();
      lat++;
      if (lat == 63) check("round_at_63", 256'(round), 256'd63);
      if (lat == 64) begin
        check("round_hold_63", 256'(round), 256'd63);
        check("busy_in_final", 256'(busy), 256'd1);
      end
    end
    start = 1'b0;
    check("latency", 256'(lat), 256'd65);
  endtask

  initial begin
    int lat;
    int nd;
    int cyc;
    logic [255:0] zero_exp;

    reset_n  = 1'b0;
    start    = 1'b0;
    state_in = '0;
    block_in = '0;
    repeat (3) tick();
    check("rst_busy",  256'(busy),  256'd0);
    check("rst_done",  256'(done),  256'd0);
    check("rst_round", 256'(round), 256'd0);
    check("rst_out",   state_out,   256'd0);
    reset_n = 1'b1;

    // "abc" block, first start right after reset release
    state_in = IV;
    block_in = ABC;
    start    = 1'b1;
    tick();
    start = 1'b0;
    check("e0_busy",  256'(busy),  256'd1);
    check("e0_round", 256'(round), 256'd0);
    tick();
    check("e1_work",  dut.work_q,  ABC_R1);
    check("e1_round", 256'(round), 256'd1);
    wait_done(1, 1'b0, lat);
    check("abc_out",       state_out,   ABC_EXP);
    check("done_busy_low", 256'(busy),  256'd0);
    check("done_round_0",  256'(round), 256'd0);
    tick();
    check("done_pulse_1cy", 256'(done), 256'd0);
    check("out_held",       state_out,  ABC_EXP);

    // Start pokes while busy are ignored; inputs change after acceptance
    state_in = IV;
    block_in = ABC;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    state_in = ~IV;
    block_in = ~ABC;
    wait_done(0, 1'b1, lat);
    check("poke_out", state_out, ABC_EXP);
    nd = 0;
    repeat (80) begin
      tick();
      if (done) nd++;
    end
    check("poke_extra_done", 256'(nd), 256'd0);
    check("poke_out_held",   state_out, ABC_EXP);

    // Reset at round 30, then restart immediately
    state_in = IV;
    block_in = ABC;
    start    = 1'b1;
    tick();
    start = 1'b0;
    repeat (30) tick();
    check("pre_rst_round", 256'(round), 256'd30);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_busy",  256'(busy),  256'd0);
    check("mid_rst_done",  256'(done),  256'd0);
    check("mid_rst_round", 256'(round), 256'd0);
    check("mid_rst_out",   state_out,   256'd0);
    check("mid_rst_work",  dut.work_q,  256'd0);
    check("mid_rst_win",   256'(dut.win_q[511:256] | dut.win_q[255:0]), 256'd0);
    repeat (2) tick();
    check("held_rst_done", 256'(done), 256'd0);
    reset_n  = 1'b1;
    state_in = IV;
    block_in = ABC;
    start    = 1'b1;
    tick();
    start = 1'b0;
    check("restart_busy", 256'(busy), 256'd1);
    wait_done(0, 1'b0, lat);
    check("restart_out", state_out, ABC_EXP);
    tick();

    // Start held high: three blocks back to back, 66 cycles apart
    state_in = IV;
    block_in = ABC;
    start    = 1'b1;
    tick();
    nd  = 0;
    cyc = 0;
    while (nd < 3 && cyc < 300) begin
      tick();
      cyc++;
      if (done) begin
        nd++;
        check("b2b_cycle", 256'(cyc), 256'(65 + 66 * (nd - 1)));
        check("b2b_out",   state_out, ABC_EXP);
        if (nd == 3) start = 1'b0;
      end
    end
    start = 1'b0;
    check("b2b_count", 256'(nd), 256'd3);
    tick();
    check("b2b_idle", 256'(busy), 256'd0);

    // All-zero chaining value and block
    zero_exp = sha_model(256'd0, 512'd0);
    state_in = '0;
    block_in = '0;
    start    = 1'b1;
    tick();
    start = 1'b0;
    wait_done(0, 1'b0, lat);
    check("zero_out", state_out, zero_exp);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
